// File: rtl/alien_row_renderer_if.sv
// rtl/alien_row_renderer_if.sv - request/acknowledge and plot-bus bundle for alien_row_renderer
//
// Purpose: groups the alien-row controller's requests and the renderer's
//          plot bus and acknowledgements into one bundle.
// Signals:
//   kill1..kill5, moveDown        controller -> renderer, one-cycle requests
//   alienTopX/BottomX (8b)        inclusive X corners, valid with killN
//   alienTopY/BottomY (7b)        inclusive Y corners, valid with killN
//   x (8b), y (7b), colour (3b)   plot coordinates/colour, 0 when plot=0
//   plot                          pixel write strobe
//   cleared1..cleared5            one-cycle done pulse per slot
//   clearedShift                  one-cycle done pulse for a shift
//   busy                          renderer not in IDLE
// Modports: master = controller side, slave = renderer side.
interface alien_row_renderer_if;
    logic       kill1, kill2, kill3, kill4, kill5;
    logic       moveDown;
    logic [7:0] alienTopX, alienBottomX;
    logic [6:0] alienTopY, alienBottomY;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       cleared1, cleared2, cleared3, cleared4, cleared5;
    logic       clearedShift;
    logic       busy;

    modport master (
        output kill1, kill2, kill3, kill4, kill5, moveDown,
        output alienTopX, alienBottomX, alienTopY, alienBottomY,
        input  x, y, colour, plot,
        input  cleared1, cleared2, cleared3, cleared4, cleared5, clearedShift, busy
    );

    modport slave (
        input  kill1, kill2, kill3, kill4, kill5, moveDown,
        input  alienTopX, alienBottomX, alienTopY, alienBottomY,
        output x, y, colour, plot,
        output cleared1, cleared2, cleared3, cleared4, cleared5, clearedShift, busy
    );
endinterface

// File: rtl/alien_row_renderer.sv
// rtl/alien_row_renderer.sv - pixel sweeper answering alien-row kill/shift requests
//
// Purpose: erases killed alien rectangles and shifts the whole row down one
//          pixel by sweeping pixels onto the VGA plot bus, one per cycle, then
//          pulses the matching acknowledge. Owns the row's top Y and alive mask.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   bus    alien_row_renderer_if.slave (requests in; plot bus, acks, busy out)
// Build option: ALIEN_INIT_DRAW_EN - when defined, paints all five aliens
//   after reset before accepting requests; otherwise reset goes to IDLE.
module alien_row_renderer #(
    parameter int         WIDTH        = 12,
    parameter int         HEIGHT       = 10,
    parameter int         GAP          = 20,
    parameter int         START_X      = 10,
    parameter int         START_Y      = 10,
    parameter logic [2:0] ALIEN_COLOUR = 3'b010,
    parameter logic [2:0] BG_COLOUR    = 3'b000
) (
    input logic                 clk,
    input logic                 reset,
    alien_row_renderer_if.slave bus
);
    localparam int         SLOT_PITCH  = WIDTH + GAP;
    localparam logic [6:0] ROW_TOP_MAX = 7'(119 - HEIGHT - 1);

    typedef enum logic [2:0] {
`ifdef ALIEN_INIT_DRAW_EN
        INIT_DRAW,
`endif
        IDLE, ERASE_RECT, ACK_KILL, SHIFT_SWEEP, ACK_SHIFT
    } state_t;

    typedef struct packed {
        logic       p;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    state_t     state;
    logic [7:0] top_x, bot_x;
    logic [6:0] top_y, bot_y;
    logic [2:0] kill_slot;
    logic [4:0] alive;
    logic [6:0] row_top;
    logic [2:0] sh_slot;
    logic       sh_phase;
    logic [7:0] sh_col;
    logic [7:0] x_r;
    logic [6:0] y_r;
    logic [2:0] colour_r;
    logic       plot_r;
    logic [4:0] cleared_r;
    logic       cleared_shift_r;

    assign bus.x            = x_r;
    assign bus.y            = y_r;
    assign bus.colour       = colour_r;
    assign bus.plot         = plot_r;
    assign bus.cleared1     = cleared_r[0];
    assign bus.cleared2     = cleared_r[1];
    assign bus.cleared3     = cleared_r[2];
    assign bus.cleared4     = cleared_r[3];
    assign bus.cleared5     = cleared_r[4];
    assign bus.clearedShift = cleared_shift_r;
    assign bus.busy         = (state != IDLE);

    function automatic logic [8:0] slot_left(input logic [2:0] s);
        return 9'(START_X) + 9'(s) * 9'(SLOT_PITCH);
    endfunction

    // One pixel of the shift sweep: phase 0 erases the old top row, phase 1
    // draws the new bottom row. Dead slots and a saturated row emit nothing.
    function automatic pix_t shift_px(input logic [2:0] s, input logic ph,
                                      input logic [7:0] col, input logic [4:0] alv,
                                      input logic [6:0] rt);
        pix_t       r;
        logic [8:0] sx;
        logic [7:0] sy;
        sx = slot_left(s) + {1'b0, col};
        sy = ph ? ({1'b0, rt} + 8'(HEIGHT + 1)) : {1'b0, rt};
        r  = '0;
        if (alv[s] && (rt < ROW_TOP_MAX)) begin
            r.p = 1'b1;
            r.x = sx[7:0];
            r.y = sy[6:0];
            r.c = ph ? ALIEN_COLOUR : BG_COLOUR;
        end
        return r;
    endfunction

    // Request priority among kills (moveDown is checked first in IDLE).
    logic       kill_any;
    logic [2:0] kill_idx;
    always_comb begin
        kill_any = 1'b1;
        kill_idx = 3'd0;
        if      (bus.kill1) kill_idx = 3'd0;
        else if (bus.kill2) kill_idx = 3'd1;
        else if (bus.kill3) kill_idx = 3'd2;
        else if (bus.kill4) kill_idx = 3'd3;
        else if (bus.kill5) kill_idx = 3'd4;
        else                kill_any = 1'b0;
    end

    // Rectangle stepping. ">=" makes a degenerate axis (bottom < top) stop
    // on its top value; x+1 cannot wrap because it only happens when x < bot.
    logic       rect_last_x, rect_last;
    logic [8:0] x_inc;
    logic [7:0] y_inc;
    logic [7:0] step_x;
    logic [6:0] step_y;
    always_comb begin
        rect_last_x = (x_r >= bot_x);
        rect_last   = rect_last_x && (y_r >= bot_y);
        x_inc       = {1'b0, x_r} + 9'd1;
        y_inc       = {1'b0, y_r} + 8'd1;
        step_x      = rect_last_x ? top_x : x_inc[7:0];
        step_y      = rect_last_x ? y_inc[6:0] : y_r;
    end

    // Shift sweep counters: column inner, phase middle, slot outer.
    logic       sh_last_col, sh_done, nxt_phase;
    logic [7:0] nxt_col;
    logic [2:0] nxt_slot;
    pix_t       pix_start, pix_next;
    always_comb begin
        sh_last_col = (sh_col == 8'(WIDTH));
        sh_done     = sh_last_col && sh_phase && (sh_slot == 3'd4);
        nxt_col     = sh_last_col ? 8'd0 : sh_col + 8'd1;
        nxt_phase   = sh_last_col ? ~sh_phase : sh_phase;
        nxt_slot    = (sh_last_col && sh_phase) ? sh_slot + 3'd1 : sh_slot;
        pix_start   = shift_px(3'd0, 1'b0, 8'd0, alive, row_top);
        pix_next    = shift_px(nxt_slot, nxt_phase, nxt_col, alive, row_top);
    end

`ifdef ALIEN_INIT_DRAW_EN
    logic [8:0] init_next_left;
    always_comb init_next_left = slot_left(kill_slot + 3'd1);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
`ifdef ALIEN_INIT_DRAW_EN
            state <= INIT_DRAW;
            top_x <= 8'(START_X);
            bot_x <= 8'(START_X + WIDTH);
            top_y <= 7'(START_Y);
            bot_y <= 7'(START_Y + HEIGHT);
`else
            state <= IDLE;
            top_x <= '0;
            bot_x <= '0;
            top_y <= '0;
            bot_y <= '0;
`endif
            kill_slot       <= '0;
            alive           <= 5'b11111;
            row_top         <= 7'(START_Y);
            sh_slot         <= '0;
            sh_phase        <= 1'b0;
            sh_col          <= '0;
            x_r             <= '0;
            y_r             <= '0;
            colour_r        <= '0;
            plot_r          <= 1'b0;
            cleared_r       <= '0;
            cleared_shift_r <= 1'b0;
        end else begin
            cleared_r       <= '0;
            cleared_shift_r <= 1'b0;
            case (state)
`ifdef ALIEN_INIT_DRAW_EN
                // First cycle after reset has plot=0 and only primes the sweep.
                INIT_DRAW: begin
                    if (!plot_r) begin
                        plot_r   <= 1'b1;
                        x_r      <= top_x;
                        y_r      <= top_y;
                        colour_r <= ALIEN_COLOUR;
                    end else if (rect_last) begin
                        if (kill_slot == 3'd4) begin
                            state    <= IDLE;
                            plot_r   <= 1'b0;
                            x_r      <= '0;
                            y_r      <= '0;
                            colour_r <= '0;
                        end else begin
                            kill_slot <= kill_slot + 3'd1;
                            top_x     <= init_next_left[7:0];
                            bot_x     <= 8'(init_next_left + 9'(WIDTH));
                            x_r       <= init_next_left[7:0];
                            y_r       <= top_y;
                        end
                    end else begin
                        x_r <= step_x;
                        y_r <= step_y;
                    end
                end
`endif
                IDLE: begin
                    if (bus.moveDown) begin
                        state    <= SHIFT_SWEEP;
                        sh_slot  <= '0;
                        sh_phase <= 1'b0;
                        sh_col   <= '0;
                        {plot_r, x_r, y_r, colour_r} <= pix_start;
                    end else if (kill_any) begin
                        state     <= ERASE_RECT;
                        kill_slot <= kill_idx;
                        top_x     <= bus.alienTopX;
                        bot_x     <= bus.alienBottomX;
                        top_y     <= bus.alienTopY;
                        bot_y     <= bus.alienBottomY;
                        x_r       <= bus.alienTopX;
                        y_r       <= bus.alienTopY;
                        colour_r  <= BG_COLOUR;
                        plot_r    <= 1'b1;
                    end
                end
                ERASE_RECT: begin
                    if (rect_last) begin
                        state                <= ACK_KILL;
                        cleared_r[kill_slot] <= 1'b1;
                        plot_r               <= 1'b0;
                        x_r                  <= '0;
                        y_r                  <= '0;
                        colour_r             <= '0;
                    end else begin
                        x_r <= step_x;
                        y_r <= step_y;
                    end
                end
                ACK_KILL: begin
                    alive[kill_slot] <= 1'b0;
                    state            <= IDLE;
                end
                SHIFT_SWEEP: begin
                    if (sh_done) begin
                        state           <= ACK_SHIFT;
                        cleared_shift_r <= 1'b1;
                        {plot_r, x_r, y_r, colour_r} <= '0;
                    end else begin
                        sh_slot  <= nxt_slot;
                        sh_phase <= nxt_phase;
                        sh_col   <= nxt_col;
                        {plot_r, x_r, y_r, colour_r} <= pix_next;
                    end
                end
                ACK_SHIFT: begin
                    if (row_top < ROW_TOP_MAX) row_top <= row_top + 7'd1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alien_row_renderer.sv
// tb/tb_alien_row_renderer.sv - directed self-checking bench for alien_row_renderer
module tb_alien_row_renderer;
    logic clk   = 1'b0;
    logic reset = 1'b1;

    alien_row_renderer_if bus();

    alien_row_renderer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef ALIEN_INIT_DRAW_EN
    localparam int RESET_BUSY = 1;
`else
    localparam int RESET_BUSY = 0;
`endif

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [4:0] alive_m;
    int         rt_m;
    logic [4:0] clr;

    assign clr = {bus.cleared5, bus.cleared4, bus.cleared3, bus.cleared2, bus.cleared1};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic set_kill(input int n, input logic v);
        case (n)
            1: bus.kill1 = v;
            2: bus.kill2 = v;
            3: bus.kill3 = v;
            4: bus.kill4 = v;
            default: bus.kill5 = v;
        endcase
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000 && bus.busy; i++) tick();
        chk("wait_idle", int'(bus.busy), 0);
    endtask

    // Expected plot bus for shift sweep cycle c (0..129), row at rt_m.
    task automatic shift_exp(input int c, output int ep, output int ex,
                             output int ey, output int ec);
        int slot, ph, col;
        slot = c / 26;
        ph   = (c % 26) / 13;
        col  = c % 13;
        ep = 0; ex = 0; ey = 0; ec = 0;
        if (alive_m[slot] && rt_m < 108) begin
            ep = 1;
            ex = 10 + slot * 32 + col;
            ey = (ph == 1) ? rt_m + 11 : rt_m;
            ec = (ph == 1) ? 2 : 0;
        end
    endtask

    task automatic run_kill(input int n, input int tx, input int ty,
                            input int bx, input int by, input string tag);
        int nx, ny, p, errs, ex, ey, fx, fy, lx, ly;
        bus.alienTopX    = 8'(tx);
        bus.alienTopY    = 7'(ty);
        bus.alienBottomX = 8'(bx);
        bus.alienBottomY = 7'(by);
        set_kill(n, 1'b1);
        tick();
        set_kill(n, 1'b0);
        nx = (bx >= tx) ? bx - tx + 1 : 1;
        ny = (by >= ty) ? by - ty + 1 : 1;
        p  = nx * ny;
        errs = 0; fx = -1; fy = -1; lx = -1; ly = -1;
        for (int i = 0; i < p; i++) begin
            ex = tx + i % nx;
            ey = ty + i / nx;
            if (int'(bus.plot) != 1 || int'(bus.x) != ex || int'(bus.y) != ey ||
                int'(bus.colour) != 0 || clr != 5'd0) errs++;
            if (i == 0)     begin fx = int'(bus.x); fy = int'(bus.y); end
            if (i == p - 1) begin lx = int'(bus.x); ly = int'(bus.y); end
            tick();
        end
        chk({tag, "_pixels"}, errs, 0);
        chk({tag, "_first_x"}, fx, tx);
        chk({tag, "_first_y"}, fy, ty);
        chk({tag, "_last_x"}, lx, tx + nx - 1);
        chk({tag, "_last_y"}, ly, ty + ny - 1);
        chk({tag, "_ack"}, int'(clr), 1 << (n - 1));
        chk({tag, "_ack_plot"}, int'(bus.plot), 0);
        tick();
        chk({tag, "_ack_end"}, int'(clr), 0);
        chk({tag, "_idle"}, int'(bus.busy), 0);
        alive_m[n-1] = 1'b0;
    endtask

    task automatic run_shift(input logic with_kill3, input string tag);
        int errs, ep, ex, ey, ec, fx, fy, fc, dy, dc;
        bus.moveDown = 1'b1;
        if (with_kill3) bus.kill3 = 1'b1;
        tick();
        bus.moveDown = 1'b0;
        bus.kill3    = 1'b0;
        errs = 0; fx = -1; fy = -1; fc = -1; dy = -1; dc = -1;
        for (int c = 0; c < 130; c++) begin
            bus.kill2 = (with_kill3 && c == 20);
            shift_exp(c, ep, ex, ey, ec);
            if (int'(bus.plot) != ep || int'(bus.x) != ex || int'(bus.y) != ey ||
                int'(bus.colour) != ec || clr != 5'd0 || bus.clearedShift) errs++;
            if (c == 0)  begin fx = int'(bus.x); fy = int'(bus.y); fc = int'(bus.colour); end
            if (c == 13) begin dy = int'(bus.y); dc = int'(bus.colour); end
            tick();
        end
        bus.kill2 = 1'b0;
        chk({tag, "_sweep"}, errs, 0);
        shift_exp(0, ep, ex, ey, ec);
        chk({tag, "_first_x"}, fx, ex);
        chk({tag, "_first_y"}, fy, ey);
        chk({tag, "_first_colour"}, fc, ec);
        shift_exp(13, ep, ex, ey, ec);
        chk({tag, "_draw_y"}, dy, ey);
        chk({tag, "_draw_colour"}, dc, ec);
        chk({tag, "_ack"}, int'(bus.clearedShift), 1);
        chk({tag, "_ack_plot"}, int'(bus.plot), 0);
        tick();
        chk({tag, "_ack_end"}, int'(bus.clearedShift), 0);
        chk({tag, "_idle"}, int'(bus.busy), 0);
        if (with_kill3) begin
            tick();
            chk({tag, "_no_kill_ack"}, int'(clr), 0);
        end
        if (rt_m < 108) rt_m++;
    endtask

    initial begin
        int errs;
        bus.kill1 = 0; bus.kill2 = 0; bus.kill3 = 0; bus.kill4 = 0; bus.kill5 = 0;
        bus.moveDown = 0;
        bus.alienTopX = 0; bus.alienBottomX = 0; bus.alienTopY = 0; bus.alienBottomY = 0;
        alive_m = 5'b11111;
        rt_m    = 10;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_plot", int'(bus.plot), 0);
        chk("rst_x", int'(bus.x), 0);
        chk("rst_y", int'(bus.y), 0);
        chk("rst_colour", int'(bus.colour), 0);
        chk("rst_cleared", int'(clr), 0);
        chk("rst_cleared_shift", int'(bus.clearedShift), 0);
        chk("rst_busy", int'(bus.busy), RESET_BUSY);
        reset = 1'b0;
        wait_idle();

        run_shift(1'b0, "shift1");
        run_shift(1'b0, "shift2");
        run_kill(1, 10, 20, 22, 30, "kill1");
        run_kill(3, 74, 12, 86, 22, "kill3");
        run_shift(1'b0, "shift_dead");
        run_shift(1'b1, "shift_prio");
        run_kill(5, 50, 5, 40, 7, "kill5_degx");
        run_kill(4, 60, 9, 62, 3, "kill4_degy");

        bus.moveDown = 1'b1;
        tick();
        bus.moveDown = 1'b0;
        repeat (50) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_plot", int'(bus.plot), 0);
        chk("midrst_busy", int'(bus.busy), RESET_BUSY);
        errs = 0;
        for (int i = 0; i < 135; i++) begin
            if (bus.clearedShift) errs++;
            tick();
        end
        chk("midrst_no_ack", errs, 0);
        rt_m    = 10;
        alive_m = 5'b11111;
        wait_idle();
        run_shift(1'b0, "shift_after_rst");

        while (rt_m < 108) run_shift(1'b0, "sat_climb");
        run_shift(1'b0, "sat_hold1");
        run_shift(1'b0, "sat_hold2");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
